// File: rtl/i_o_timer_generator.sv
// Purpose: free-running baud-rate tick generator; emits a one-cycle `active` strobe per bit time.
// Latency: first tick after DIVISOR edges (integer) or ceil(2^ACC_WIDTH/INC) edges (fractional) from reset release.
// Backpressure: none; consumers sample `active` as a clock enable and cannot stall or hold it.
module i_o_timer_generator #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned FRACTIONAL  = 0,
  parameter int unsigned ACC_WIDTH   = 32
) (
  input  logic clk,
  input  logic rst_n,
  output logic active
);

  // Clock cycles per bit, rounded to nearest.
  localparam int unsigned DIVISOR = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;

  // Reject configurations that would produce adjacent or undefined ticks.
  if (DIVISOR < 2) begin : g_bad_divisor
    $error("i_o_timer_generator: DIVISOR must be at least 2");
  end
  if (FRACTIONAL > 1) begin : g_bad_mode
    $error("i_o_timer_generator: FRACTIONAL must be 0 or 1");
  end

  logic active_q;
  logic active_d;

  if (FRACTIONAL == 0) begin : g_int
    localparam int unsigned CNT_W = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count 0..DIVISOR-1 and strobe on the wrap, giving an exact jitter-free period.
    always_comb begin
      cnt_d    = cnt_q + CNT_W'(1);
      active_d = 1'b0;
      if (cnt_q == TERMINAL) begin
        cnt_d    = '0;
        active_d = 1'b1;
      end
    end

    // Divider counter register; reset discards any partial period.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end else begin : g_frac
    // Phase increment rounded to nearest; wide arithmetic keeps the shift exact.
    localparam logic [127:0] INC_WIDE =
      ((128'(BAUD_RATE) << ACC_WIDTH) + 128'(CLK_FREQ_HZ / 2)) / 128'(CLK_FREQ_HZ);
    localparam logic [ACC_WIDTH-1:0] INC = INC_WIDE[ACC_WIDTH-1:0];

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 carry;

    // Accumulate phase modulo 2^ACC_WIDTH; each overflow is one bit time.
    always_comb begin
      {carry, acc_d} = {1'b0, acc_q} + {1'b0, INC};
      active_d       = carry;
    end

    // Phase accumulator register; reset restarts phase from zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end
  end

  // Strobe is registered so consumers see a glitch-free enable with no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active_d;
    end
  end

  assign active = active_q;

endmodule

// File: tb/tb_i_o_timer_generator.sv
// Purpose: randomized-reset scoreboard bench for several tick generator configurations.
// Latency: expected strobe per edge is queued at posedge and compared at the following negedge.
// Backpressure: none; the DUT is free-running.
module tb_i_o_timer_generator;

  logic clk;
  logic rst_n;
  logic a_d10, a_d3a, a_d3b, a_frac, a_dflt;

  int checks = 0;
  int errors = 0;
  int n = 0;                 // edges since reset release, 0 while in reset
  logic [4:0] exp_q[$];

  bit stat_en = 0;
  int last10, last3a, last3b, lastf, lastd, fcnt, dcnt;

  localparam int INC_REF = (300 * 256 + 1000 / 2) / 1000;   // 77

  i_o_timer_generator #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .FRACTIONAL(0), .ACC_WIDTH(32))
    u_d10 (.clk(clk), .rst_n(rst_n), .active(a_d10));
  i_o_timer_generator #(.CLK_FREQ_HZ(1000), .BAUD_RATE(300), .FRACTIONAL(0), .ACC_WIDTH(32))
    u_d3a (.clk(clk), .rst_n(rst_n), .active(a_d3a));
  i_o_timer_generator #(.CLK_FREQ_HZ(1000), .BAUD_RATE(400), .FRACTIONAL(0), .ACC_WIDTH(32))
    u_d3b (.clk(clk), .rst_n(rst_n), .active(a_d3b));
  i_o_timer_generator #(.CLK_FREQ_HZ(1000), .BAUD_RATE(300), .FRACTIONAL(1), .ACC_WIDTH(8))
    u_frac (.clk(clk), .rst_n(rst_n), .active(a_frac));
  i_o_timer_generator u_dflt (.clk(clk), .rst_n(rst_n), .active(a_dflt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer divider ticks on every multiple of d edges.
  function automatic logic tick_int(int k, int d);
    return (k > 0) && (k % d == 0);
  endfunction

  // Reference model: fractional engine ticks when floor(k*INC/256) steps up.
  function automatic logic tick_frac(int k);
    longint a, b;
    a = longint'(k) * INC_REF;
    b = longint'(k - 1) * INC_REF;
    return (k > 0) && ((a / 256) != (b / 256));
  endfunction

  function automatic logic [4:0] expect_vec(int k);
    return {tick_int(k, 868), tick_frac(k), tick_int(k, 3), tick_int(k, 3), tick_int(k, 10)};
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic check_rng(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, v, lo, hi, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d10"}, a_d10, 1'b0);
    check({tag, "_d3a"}, a_d3a, 1'b0);
    check({tag, "_d3b"}, a_d3b, 1'b0);
    check({tag, "_frac"}, a_frac, 1'b0);
    check({tag, "_dflt"}, a_dflt, 1'b0);
  endtask

  // Model: on every edge, push what each instance must show after that edge.
  initial forever begin
    @(posedge clk);
    if (rst_n === 1'b1) begin
      n = n + 1;
      exp_q.push_back(expect_vec(n));
    end else begin
      n = 0;
      exp_q.push_back(5'b0);
    end
  end

  // Monitor: pop one expectation per cycle and compare; also gather tick spacing.
  initial forever begin
    logic [4:0] e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("d10", a_d10, e[0]);
      check("d3a", a_d3a, e[1]);
      check("d3b", a_d3b, e[2]);
      check("frac", a_frac, e[3]);
      check("dflt", a_dflt, e[4]);
    end
    if (stat_en) begin
      if (a_d10 === 1'b1) begin
        if (last10 > 0) check_rng("d10_gap", n - last10, 10, 10);
        else check_rng("d10_first", n, 10, 10);
        last10 = n;
      end
      if (a_d3a === 1'b1) begin
        if (last3a > 0) check_rng("d3a_gap", n - last3a, 3, 3);
        else check_rng("d3a_first", n, 3, 3);
        last3a = n;
      end
      if (a_d3b === 1'b1) begin
        if (last3b > 0) check_rng("d3b_gap", n - last3b, 3, 3);
        else check_rng("d3b_first", n, 3, 3);
        last3b = n;
      end
      if (a_frac === 1'b1) begin
        if (lastf > 0) check_rng("frac_gap", n - lastf, 3, 4);
        else check_rng("frac_first", n, 4, 4);
        lastf = n;
        if (n <= 1000) fcnt++;
      end
      if (a_dflt === 1'b1) begin
        if (lastd > 0) check_rng("dflt_gap", n - lastd, 868, 868);
        else check_rng("dflt_first", n, 868, 868);
        lastd = n;
        dcnt++;
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: random reset timing, mid-count and mid-tick resets, then a long clean run.
  initial begin
    bit found;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset_state");
    #1 rst_n = 1'b1;

    // Reset between edges 6 and 7 of the divide-by-10 engine.
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_midcount");
    repeat ($urandom_range(1, 3)) @(negedge clk);
    #2 rst_n = 1'b1;

    // Reset while the divide-by-10 strobe is high: it must fall with no clock edge.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      #1 if (a_d10 === 1'b1) found = 1'b1;
    end
    check("wait_d10_tick", found, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_during_tick");
    repeat ($urandom_range(1, 4)) @(negedge clk);
    #2 rst_n = 1'b1;

    // Random run lengths interrupted by random resets.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 40)) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_random");
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #2 rst_n = 1'b1;
    end

    // Long clean run for spacing and rate statistics.
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    last10 = 0; last3a = 0; last3b = 0; lastf = 0; lastd = 0; fcnt = 0; dcnt = 0;
    #2 rst_n = 1'b1;
    stat_en = 1'b1;
    repeat (868 * 11 + 20) @(negedge clk);
    #3;
    check_rng("frac_ticks_in_1000", fcnt, 300, 301);
    check_rng("dflt_tick_count", dcnt, 11, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
